// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA arbiter.
package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_ACTIVE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
  localparam logic [15:0] HI_REGION_BASE = 16'hFF00;
  localparam int unsigned OAM_BYTES      = 160;

endpackage

// File: rtl/oam_dma_arbiter_engine.sv
// OAM DMA engine: phase counter, transfer state machine, byte index and read latch.
module oam_dma_engine
  import oam_dma_arbiter_pkg::*;
#(
  parameter int unsigned DMA_LEN     = OAM_BYTES,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [7:0]  src,
  input  logic [7:0]  ext_rdata,
  output logic        phase3,
  output logic        active,
  output logic        busy,
  output logic [15:0] dma_addr,
  output logic        dma_req_read,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we
);

  localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
  localparam logic [7:0] LAST_DELAY = 8'(START_DELAY - 1);

  dma_state_t state_q, state_d;
  logic [1:0] phase_q;
  logic [7:0] idx_q, idx_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic [7:0] latch_q;

  // State, counters and read latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DMA_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      dcnt_q  <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_q + 2'd1;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      if (state_q == DMA_ACTIVE && phase_q == 2'd2) begin
        latch_q <= ext_rdata;
      end
    end
  end

  // Next state; a trigger overrides the normal step, so the current
  // ACTIVE byte still completes its phase-3 write before the restart.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    if (phase_q == 2'd3) begin
      case (state_q)
        DMA_START: begin
          if (dcnt_q == LAST_DELAY) begin
            state_d = DMA_ACTIVE;
            idx_d   = '0;
          end else begin
            dcnt_d = dcnt_q + 8'd1;
          end
        end
        DMA_ACTIVE: begin
          if (idx_q == LAST_IDX) begin
            state_d = DMA_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        default: state_d = DMA_IDLE;
      endcase
      if (trigger) begin
        state_d = DMA_START;
        idx_d   = '0;
        dcnt_d  = '0;
      end
    end
  end

  // Bus and OAM outputs decoded from registered state
  always_comb begin
    phase3       = (phase_q == 2'd3);
    active       = (state_q == DMA_ACTIVE);
    busy         = (state_q != DMA_IDLE);
    dma_addr     = active ? {src, idx_q} : '0;
    dma_req_read = active && (phase_q == 2'd1 || phase_q == 2'd2);
    oam_we       = active && (phase_q == 2'd3);
    oam_addr     = oam_we ? idx_q : '0;
    oam_wdata    = oam_we ? latch_q : '0;
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: FF46 source register, source clamp and CPU bus routing.
module oam_dma_arbiter #(
  parameter int unsigned DMA_LEN      = oam_dma_arbiter_pkg::OAM_BYTES,
  parameter logic [15:0] DMA_REG_ADDR = oam_dma_arbiter_pkg::DMA_REG_ADDR,
  parameter int unsigned START_DELAY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        cpu_req_read,
  input  logic        cpu_req_write,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  output logic        ext_req_read,
  output logic        ext_req_write,
  output logic [15:0] hi_addr,
  output logic [7:0]  hi_wdata,
  input  logic [7:0]  hi_rdata,
  output logic        hi_req_read,
  output logic        hi_req_write,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);
  import oam_dma_arbiter_pkg::*;

  logic [7:0]  dma_src;
  logic        reg_hit, hi_hit, reg_load;
  logic        phase3, active;
  logic [15:0] dma_addr;
  logic        dma_req_read;

  assign reg_hit  = (cpu_addr == DMA_REG_ADDR);
  assign hi_hit   = (cpu_addr[15:8] == HI_REGION_BASE[15:8]) && !reg_hit;
  assign reg_load = phase3 && cpu_req_write && reg_hit;

  // FF46 source register; E0-FF pages fold down so DMA never reads above DFFF
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_src <= 8'hFF;
    end else if (reg_load) begin
      dma_src <= (cpu_wdata[7:5] == 3'b111) ? cpu_wdata - 8'h20 : cpu_wdata;
    end
  end

  oam_dma_engine #(
    .DMA_LEN     (DMA_LEN),
    .START_DELAY (START_DELAY)
  ) u_engine (
    .clk          (clk),
    .reset        (reset),
    .trigger      (reg_load),
    .src          (dma_src),
    .ext_rdata    (ext_rdata),
    .phase3       (phase3),
    .active       (active),
    .busy         (dma_active),
    .dma_addr     (dma_addr),
    .dma_req_read (dma_req_read),
    .oam_addr     (oam_addr),
    .oam_wdata    (oam_wdata),
    .oam_we       (oam_we)
  );

  // CPU routing: FF46 local, FFxx to hi port, rest to ext unless DMA owns it
  always_comb begin
    ext_addr      = '0;
    ext_wdata     = '0;
    ext_req_read  = 1'b0;
    ext_req_write = 1'b0;
    hi_addr       = '0;
    hi_wdata      = '0;
    hi_req_read   = 1'b0;
    hi_req_write  = 1'b0;
    cpu_rdata     = 8'hFF;
    if (reg_hit) begin
      cpu_rdata = dma_src;
    end else if (hi_hit) begin
      hi_addr      = cpu_addr;
      hi_wdata     = cpu_wdata;
      hi_req_read  = cpu_req_read;
      hi_req_write = cpu_req_write;
      cpu_rdata    = hi_rdata;
    end else if (!active) begin
      ext_addr      = cpu_addr;
      ext_wdata     = cpu_wdata;
      ext_req_read  = cpu_req_read;
      ext_req_write = cpu_req_write;
      cpu_rdata     = ext_rdata;
    end
    if (active) begin
      ext_addr     = dma_addr;
      ext_req_read = dma_req_read;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized self-checking bench for oam_dma_arbiter against a timeline model.
module tb_oam_dma_arbiter;

  localparam int DMA_LEN     = 160;
  localparam int START_DELAY = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_req_read, cpu_req_write;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata, ext_rdata;
  logic        ext_req_read, ext_req_write;
  logic [15:0] hi_addr;
  logic [7:0]  hi_wdata, hi_rdata;
  logic        hi_req_read, hi_req_write;
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_we, dma_active;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: clocks since reset, M-cycle of the last FF46 write, source
  int         n        = 0;
  int         last_m   = 0;
  bit         has_trig = 1'b0;
  logic [7:0] m_src    = 8'hFF;
  bit         chk_en   = 1'b0;

  oam_dma_arbiter #(
    .DMA_LEN      (DMA_LEN),
    .DMA_REG_ADDR (16'hFF46),
    .START_DELAY  (START_DELAY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_req_read  (cpu_req_read),
    .cpu_req_write (cpu_req_write),
    .ext_addr      (ext_addr),
    .ext_wdata     (ext_wdata),
    .ext_rdata     (ext_rdata),
    .ext_req_read  (ext_req_read),
    .ext_req_write (ext_req_write),
    .hi_addr       (hi_addr),
    .hi_wdata      (hi_wdata),
    .hi_rdata      (hi_rdata),
    .hi_req_read   (hi_req_read),
    .hi_req_write  (hi_req_write),
    .oam_addr      (oam_addr),
    .oam_wdata     (oam_wdata),
    .oam_we        (oam_we),
    .dma_active    (dma_active)
  );

  always #5 clk = ~clk;

  // Memory contents: page C1 holds i^5A, other pages differ
  function automatic logic [7:0] dataf(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC1;
  endfunction

  function automatic logic [7:0] clampf(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  assign ext_rdata = dataf(ext_addr);
  assign hi_rdata  = hi_addr[7:0] ^ 8'hA5;

  function automatic int m_dm();
    return (n / 4) - last_m;
  endfunction

  function automatic bit m_busy();
    return has_trig && m_dm() >= 1 && m_dm() <= START_DELAY + DMA_LEN;
  endfunction

  function automatic bit m_act();
    return has_trig && m_dm() >= START_DELAY + 1 && m_dm() <= START_DELAY + DMA_LEN;
  endfunction

  function automatic int m_idx();
    return m_dm() - START_DELAY - 1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n        <= 0;
      last_m   <= 0;
      has_trig <= 1'b0;
      m_src    <= 8'hFF;
    end else begin
      if (n % 4 == 3 && cpu_req_write && cpu_addr == 16'hFF46) begin
        m_src    <= clampf(cpu_wdata);
        last_m   <= n / 4;
        has_trig <= 1'b1;
      end
      n <= n + 1;
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin : model_chk
    logic is_reg, is_hi, is_ext, act;
    int   ph;
    logic [7:0] exp_rd;
    if (chk_en) begin
      is_reg = (cpu_addr == 16'hFF46);
      is_hi  = (cpu_addr[15:8] == 8'hFF) && !is_reg;
      is_ext = !is_reg && !is_hi;
      act    = m_act();
      ph     = n % 4;
      chk("dma_active", 16'(dma_active), 16'(m_busy()));
      chk("oam_we", 16'(oam_we), 16'(act && ph == 3));
      if (act && ph == 3) begin
        chk("oam_addr", 16'(oam_addr), 16'(m_idx()));
        chk("oam_wdata", 16'(oam_wdata), 16'(dataf({m_src, 8'(m_idx())})));
      end
      chk("ext_req_read", 16'(ext_req_read),
          16'(act ? (ph == 1 || ph == 2) : (is_ext && cpu_req_read)));
      chk("ext_req_write", 16'(ext_req_write), 16'(!act && is_ext && cpu_req_write));
      if (act) chk("ext_addr_dma", ext_addr, {m_src, 8'(m_idx())});
      else if (is_ext && (cpu_req_read || cpu_req_write)) chk("ext_addr_cpu", ext_addr, cpu_addr);
      if (!act && is_ext && cpu_req_write) chk("ext_wdata", 16'(ext_wdata), 16'(cpu_wdata));
      chk("hi_req_read", 16'(hi_req_read), 16'(is_hi && cpu_req_read));
      chk("hi_req_write", 16'(hi_req_write), 16'(is_hi && cpu_req_write));
      if (is_hi && (cpu_req_read || cpu_req_write)) chk("hi_addr", hi_addr, cpu_addr);
      if (is_hi && cpu_req_write) chk("hi_wdata", 16'(hi_wdata), 16'(cpu_wdata));
      if (is_reg)      exp_rd = m_src;
      else if (is_hi)  exp_rd = cpu_addr[7:0] ^ 8'hA5;
      else if (act)    exp_rd = 8'hFF;
      else             exp_rd = dataf(cpu_addr);
      chk("cpu_rdata", 16'(cpu_rdata), 16'(exp_rd));
    end
  end

  task automatic idle();
    cpu_addr      = '0;
    cpu_wdata     = '0;
    cpu_req_read  = 1'b0;
    cpu_req_write = 1'b0;
  endtask

  task automatic tick(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
    cpu_addr      = a;
    cpu_wdata     = d;
    cpu_req_read  = r;
    cpu_req_write = w;
    @(posedge clk);
    #1;
  endtask

  // Random CPU traffic that never writes FF46
  task automatic rand_step();
    int unsigned k;
    logic [15:0] a;
    logic r, w;
    k = $urandom_range(0, 3);
    case (k)
      0:       a = 16'h8000;
      1:       a = 16'($urandom_range(0, 16'hFEFF));
      2:       a = 16'hFF00 | 16'($urandom_range(0, 255));
      default: a = 16'hFF46;
    endcase
    r = 1'($urandom_range(0, 1));
    w = !r && 1'($urandom_range(0, 1)) && (a != 16'hFF46);
    tick(a, 8'($urandom_range(0, 255)), r, w);
  endtask

  task automatic wr_ff46(input logic [7:0] v, output int nw);
    for (int g = 0; g < 8 && n % 4 != 3; g++) tick(16'h0000, 8'h00, 1'b0, 1'b0);
    nw = n;
    tick(16'hFF46, v, 1'b0, 1'b1);
    idle();
  endtask

  task automatic wait_idx(input int target, input int ph);
    int g;
    g = 0;
    while (!(m_act() && m_idx() == target && n % 4 == ph) && g < 3000) begin
      rand_step();
      g++;
    end
    idle();
    #1;
    if (g >= 3000) chk("wait_idx_timeout", 16'(m_idx()), 16'(target));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (m_busy() && g < 1000) begin
      rand_step();
      g++;
    end
    if (g >= 1000) chk("drain_timeout", 16'(dma_active), 16'(0));
    repeat (6) rand_step();
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nw, cnt, first, acnt;
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dma_active", 16'(dma_active), 16'(0));
    chk("rst_oam_we", 16'(oam_we), 16'(0));
    chk("rst_ext_req_read", 16'(ext_req_read), 16'(0));
    chk("rst_hi_req_read", 16'(hi_req_read), 16'(0));
    chk("rst_oam_addr", 16'(oam_addr), 16'(0));
    chk("rst_ext_addr", ext_addr, 16'h0000);
    cpu_addr = 16'hFF46; cpu_req_read = 1'b1;
    #1;
    chk("rst_ff46", 16'(cpu_rdata), 16'h00FF);
    idle();
    chk_en = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Full transfer from C1 with timing counts
    wr_ff46(8'hC1, nw);
    cnt = 0; first = -1; acnt = 0;
    for (int i = 0; i < 700; i++) begin
      if (oam_we) begin
        if (first < 0) first = n - nw;
        cnt++;
      end
      if (dma_active) acnt++;
      rand_step();
    end
    idle();
    chk("first_we_latency", 16'(first), 16'(8));
    chk("we_count", 16'(cnt), 16'(160));
    chk("busy_clks", 16'(acnt), 16'(644));

    // CPU write to ext while idle passes through
    cpu_addr = 16'hC000; cpu_wdata = 8'h77; cpu_req_write = 1'b1;
    #1;
    chk("idle_ext_write", 16'(ext_req_write), 16'(1));
    chk("idle_ext_wdata", 16'(ext_wdata), 16'h0077);
    @(posedge clk); #1;
    idle();

    // Blocked accesses during ACTIVE, hi region still reachable
    wr_ff46(8'hC1, nw);
    wait_idx(10, 0);
    for (int p = 0; p < 4; p++) begin
      cpu_addr = 16'h8000; cpu_req_read = 1'b1;
      #1;
      chk("blk_rdata", 16'(cpu_rdata), 16'h00FF);
      chk("blk_ext_addr", ext_addr, {8'hC1, 8'(m_idx())});
      tick(16'h8000, 8'h00, 1'b1, 1'b0);
    end
    for (int p = 0; p < 4; p++) begin
      cpu_addr = 16'hFF85; cpu_req_read = 1'b1; cpu_req_write = 1'b0;
      #1;
      chk("hi_read_active", 16'(hi_req_read), 16'(1));
      chk("hi_rdata_active", 16'(cpu_rdata), 16'h0020);
      tick(16'hFF85, 8'h00, 1'b1, 1'b0);
    end
    for (int p = 0; p < 4; p++) begin
      cpu_addr = 16'hC000; cpu_wdata = 8'h77; cpu_req_read = 1'b0; cpu_req_write = 1'b1;
      #1;
      chk("blk_ext_write", 16'(ext_req_write), 16'(0));
      tick(16'hC000, 8'h77, 1'b0, 1'b1);
    end
    idle();
    drain();

    // Source clamp: FE -> DE
    wr_ff46(8'hFE, nw);
    cpu_addr = 16'hFF46; cpu_req_read = 1'b1;
    #1;
    chk("clamp_ff46", 16'(cpu_rdata), 16'h00DE);
    idle();
    wait_idx(0, 1);
    chk("clamp_first_addr", ext_addr, 16'hDE00);
    wait_idx(159, 1);
    chk("clamp_last_addr", ext_addr, 16'hDE9F);
    drain();

    // Restart at byte 50
    wr_ff46(8'hC0, nw);
    wait_idx(50, 3);
    chk("restart_we50", 16'(oam_we), 16'(1));
    chk("restart_data50", 16'(oam_wdata), 16'(dataf(16'hC032)));
    tick(16'hFF46, 8'hD0, 1'b0, 1'b1);
    idle();
    wait_idx(0, 3);
    chk("restart_addr", ext_addr, 16'hD000);
    chk("restart_idx0", 16'(oam_addr), 16'(0));
    drain();

    // Reset at byte 80
    wr_ff46(8'hC1, nw);
    wait_idx(80, 2);
    chk("pre_rst_read", 16'(ext_req_read), 16'(1));
    reset = 1'b1;
    #1;
    chk("rst_mid_we", 16'(oam_we), 16'(0));
    chk("rst_mid_read", 16'(ext_req_read), 16'(0));
    chk("rst_mid_busy", 16'(dma_active), 16'(0));
    cpu_addr = 16'hFF46; cpu_req_read = 1'b1;
    #1;
    chk("rst_mid_ff46", 16'(cpu_rdata), 16'h00FF);
    idle();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (oam_we) cnt++;
      rand_step();
    end
    chk("post_rst_we_count", 16'(cnt), 16'(0));
    idle();

    // Random FF46 values with random traffic
    for (int t = 0; t < 2; t++) begin
      wr_ff46(8'($urandom_range(0, 255)), nw);
      drain();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
